q_int8_requantizer: RTL and testbench

// Downstream of the Q projection stage. Streams the FP32 Q matrix (4 lanes per 128-bit word) out of
// the projection output SRAM, scales each value by 2^SCALE_EXP, rounds and saturates it to INT8, and

---
 rtl/q_int8_requantizer.sv | 171 +++++++++++++++++
 tb/tb_q_int8_requantizer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_int8_requantizer.sv
// Streams FP32 Q words from the projection SRAM, scales by 2^SCALE_EXP, rounds/saturates to INT8
// and packs four source words into each 128-bit INT8 destination word.
module q_int8_requantizer #(
  parameter int SCALE_EXP = 4,
  parameter int SRC_WORDS = 128,
  parameter int SRC_AW    = 7,
  parameter int DST_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [127:0]      SRC_MEM_DOUT,
  output logic              SRC_MEM_CEB,
  output logic              SRC_MEM_WEN,
  output logic [SRC_AW-1:0] SRC_MEM_ADDR,
  output logic              DST_MEM_CEB,
  output logic              DST_MEM_WEN,
  output logic [DST_AW-1:0] DST_MEM_ADDR,
  output logic [127:0]      DST_MEM_DIN,
  output logic              busy,
  output logic              finished,
  output logic [9:0]        sat_count
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  localparam logic [SRC_AW-1:0] LastAddr = SRC_AW'(SRC_WORDS - 1);

  state_e              state_q, state_d;
  logic [SRC_AW-1:0]   rd_addr_q;
  logic                rd_ceb_q;
  logic                rd_vld_q;
  logic [1:0]          rd_slot_q;
  logic [127:0]        pack_q;
  logic                wr_ceb_q;
  logic                wr_first_q;
  logic [DST_AW-1:0]   wr_addr_q;
  logic [127:0]        wr_din_q;
  logic [9:0]          sat_q;

  logic                start;
  logic                rd_last;
  logic [8:0]          lane_res [4];
  logic [31:0]         conv_bytes;
  logic [2:0]          conv_clips;
  logic [127:0]        pack_next;
  logic [10:0]         sat_sum;

  // Returns {clip, int8}. Magnitude is taken at half-LSB resolution so one add+shift rounds
  // half away from zero; anything with unbiased exponent >7 is already >=256.
  function automatic logic [8:0] conv_lane(input logic [31:0] x);
    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] man;
    logic [23:0] sig;
    logic [23:0] t;
    logic [8:0]  mag;
    logic [4:0]  sh;
    int          e_unb;
    logic [8:0]  res;
    sgn   = x[31];
    ex    = x[30:23];
    man   = x[22:0];
    sig   = {1'b1, man};
    e_unb = int'(ex) - 127 + SCALE_EXP;
    res   = 9'd0;
    t     = '0;
    mag   = '0;
    sh    = '0;
    if (ex == 8'hFF) begin
      if (man == 23'd0) res = sgn ? {1'b1, 8'h80} : {1'b1, 8'h7F};
    end else if (ex == 8'h00) begin
      res = 9'd0;
    end else if (e_unb > 7) begin
      res = sgn ? {1'b1, 8'h80} : {1'b1, 8'h7F};
    end else if (e_unb >= -1) begin
      sh  = 5'(22 - e_unb);
      t   = sig >> sh;
      mag = 9'((t + 24'd1) >> 1);
      if (!sgn) res = (mag > 9'd127) ? {1'b1, 8'h7F} : {1'b0, mag[7:0]};
      else      res = (mag > 9'd128) ? {1'b1, 8'h80} : {1'b0, 8'(9'd0 - mag)};
    end
    return res;
  endfunction

  always_comb begin
    for (int j = 0; j < 4; j++) lane_res[j] = conv_lane(SRC_MEM_DOUT[j*32 +: 32]);
  end

  always_comb begin
    conv_bytes = '0;
    conv_clips = '0;
    for (int j = 0; j < 4; j++) begin
      conv_bytes[j*8 +: 8] = lane_res[j][7:0];
      conv_clips           = conv_clips + {2'b00, lane_res[j][8]};
    end
    pack_next                          = pack_q;
    pack_next[{rd_slot_q, 5'd0} +: 32] = conv_bytes;
    sat_sum                            = {1'b0, sat_q} + {8'd0, conv_clips};
  end

  assign start   = (state_q == StIdle) && en;
  assign rd_last = (rd_addr_q == LastAddr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StRead;
      StRead:  if (rd_last) state_d = StDrain;
      // Final destination write is on the bus and no read data is still in flight.
      StDrain: if (!rd_vld_q && !wr_ceb_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      rd_ceb_q   <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_slot_q  <= '0;
      pack_q     <= '0;
      wr_ceb_q   <= 1'b1;
      wr_first_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      sat_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= (state_q == StRead);
      rd_slot_q <= rd_addr_q[1:0];
      wr_ceb_q  <= 1'b1;
      wr_din_q  <= '0;
      if (start) begin
        rd_addr_q  <= '0;
        rd_ceb_q   <= 1'b0;
        wr_addr_q  <= '0;
        wr_first_q <= 1'b1;
        sat_q      <= '0;
      end else if (state_q == StRead) begin
        if (rd_last) rd_ceb_q  <= 1'b1;
        else         rd_addr_q <= rd_addr_q + 1'b1;
      end
      if (rd_vld_q) begin
        pack_q <= pack_next;
        sat_q  <= (sat_sum > 11'd1023) ? 10'h3FF : sat_sum[9:0];
        if (rd_slot_q == 2'd3) begin
          wr_ceb_q   <= 1'b0;
          wr_din_q   <= pack_next;
          wr_first_q <= 1'b0;
          // Advance before each write after the first, so the address never wraps past the end.
          if (!wr_first_q) wr_addr_q <= wr_addr_q + 1'b1;
        end
      end
    end
  end

  assign SRC_MEM_CEB  = rd_ceb_q;
  assign SRC_MEM_WEN  = 1'b1;
  assign SRC_MEM_ADDR = rd_addr_q;
  assign DST_MEM_CEB  = wr_ceb_q;
  assign DST_MEM_WEN  = wr_ceb_q;
  assign DST_MEM_ADDR = wr_addr_q;
  assign DST_MEM_DIN  = wr_din_q;
  assign busy         = (state_q != StIdle);
  assign finished     = (state_q == StDone);
  assign sat_count    = sat_q;

endmodule

// File: tb/tb_q_int8_requantizer.sv
// Self-checking bench for q_int8_requantizer: directed lane vectors, ramp runs, back-to-back start
// and mid-run reset, against a cycle-stamped log of destination writes.
module tb_q_int8_requantizer;

  localparam int SW = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [127:0] src_dout = '0;
  logic         src_ceb, src_wen, dst_ceb, dst_wen, busy, finished;
  logic [6:0]   src_addr;
  logic [4:0]   dst_addr;
  logic [127:0] dst_din;
  logic [9:0]   sat_count;

  always #5 clk = ~clk;

  q_int8_requantizer #(
    .SCALE_EXP(4),
    .SRC_WORDS(SW),
    .SRC_AW   (7),
    .DST_AW   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .SRC_MEM_DOUT(src_dout),
    .SRC_MEM_CEB (src_ceb),
    .SRC_MEM_WEN (src_wen),
    .SRC_MEM_ADDR(src_addr),
    .DST_MEM_CEB (dst_ceb),
    .DST_MEM_WEN (dst_wen),
    .DST_MEM_ADDR(dst_addr),
    .DST_MEM_DIN (dst_din),
    .busy        (busy),
    .finished    (finished),
    .sat_count   (sat_count)
  );

  typedef struct {
    int           cyc;
    int           addr;
    logic [127:0] din;
  } wr_t;

  typedef struct packed {
    logic [127:0] src;
    logic [31:0]  exp;
    int           clips;
  } vec_t;

  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [127:0] mem [SW];
  wr_t          wq[$];
  int           fq[$];
  wr_t          w;
  vec_t         tv [8];
  logic [127:0] got [32];
  int           t0, t1, tc, td, tbl_sat, nw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (!src_ceb) src_dout <= mem[src_addr];

  always @(negedge clk) begin
    if (!dst_ceb) begin
      w.cyc  = cyc;
      w.addr = int'(dst_addr);
      w.din  = dst_din;
      wq.push_back(w);
    end
    if (finished) fq.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fp_div16(input int n);
    int p;
    logic [31:0] r;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 10; i++) if (n >= (1 << i)) p = i;
    r        = '0;
    r[30:23] = 8'(127 + p - 4);
    r[22:0]  = 23'((n << (23 - p)) & 32'h7FFFFF);
    return r;
  endfunction

  function automatic logic [127:0] ramp_word(input int m);
    logic [127:0] r;
    int v;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      v = 16 * m + b;
      r[b*8 +: 8] = (v > 127) ? 8'd127 : 8'(v);
    end
    return r;
  endfunction

  task automatic load_ramp();
    for (int k = 0; k < SW; k++)
      for (int j = 0; j < 4; j++) mem[k][j*32 +: 32] = fp_div16(4 * k + j);
  endtask

  task automatic load_table();
    for (int k = 0; k < SW; k++) mem[k] = (k < 8) ? tv[k].src : '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_ceb"}, src_ceb, 1'b1);
    chk({tag, "_src_addr"}, src_addr, 7'd0);
    chk({tag, "_dst_ceb_wen"}, {dst_ceb, dst_wen}, 2'b11);
    chk({tag, "_dst_addr"}, dst_addr, 5'd0);
    chk({tag, "_dst_din"}, dst_din, 128'd0);
    chk({tag, "_busy_fin"}, {busy, finished}, 2'b00);
    chk({tag, "_sat"}, sat_count, 10'd0);
  endtask

  task automatic check_run(input string nm, input int ts, input int te, input bit is_ramp);
    int n, nf;
    n  = 0;
    nf = 0;
    for (int m = 0; m < 32; m++) got[m] = '0;
    foreach (wq[i]) begin
      if (wq[i].cyc >= ts && wq[i].cyc < te) begin
        chk($sformatf("%s_wr%0d_cycle", nm, n), wq[i].cyc - ts, 6 + 4 * n);
        chk($sformatf("%s_wr%0d_addr", nm, n), wq[i].addr, n);
        if (n < 32) got[n] = wq[i].din;
        n++;
      end
    end
    chk({nm, "_write_count"}, n, 32);
    foreach (fq[i]) begin
      if (fq[i] >= ts && fq[i] < te) begin
        chk({nm, "_finished_cycle"}, fq[i] - ts, 131);
        nf++;
      end
    end
    chk({nm, "_finished_count"}, nf, 1);
    if (is_ramp) begin
      for (int m = 0; m < 32; m++) chk($sformatf("%s_ramp_word%0d", nm, m), got[m], ramp_word(m));
    end else begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s_vec%0d", nm, k), got[k/4][(k%4)*32 +: 32], tv[k].exp);
      for (int m = 2; m < 32; m++) chk($sformatf("%s_zero_word%0d", nm, m), got[m], 128'd0);
    end
  endtask

  initial begin
    // lanes listed high-to-low: {lane3, lane2, lane1, lane0}
    tv[0] = '{{32'hBD000000, 32'h3F000000, 32'hBF800000, 32'h3F800000}, 32'hFF08F010, 0};
    tv[1] = '{{32'h7F800000, 32'hC1010000, 32'hC1000000, 32'h42C80000}, 32'h7F80807F, 3};
    tv[2] = '{{32'h80000000, 32'h00000001, 32'h00000000, 32'h7FC00000}, 32'h00000000, 0};
    tv[3] = '{{32'h3CF5C28F, 32'h3D800000, 32'hBDC00000, 32'h3DC00000}, 32'h0001FE02, 0};
    tv[4] = '{{32'h40FE0000, 32'hC1008000, 32'h40FF0000, 32'hFF800000}, 32'h7F807F80, 3};
    tv[5] = '{{32'h3A800000, 32'hBF780000, 32'h40400000, 32'h3D000000}, 32'h00F03001, 0};
    tv[6] = '{{32'h7F800001, 32'h00800000, 32'h41000000, 32'hC0FF0000}, 32'h00007F80, 1};
    tv[7] = '{{32'hC0000000, 32'h40000000, 32'h3F000000, 32'hC2C80000}, 32'hE0200880, 1};
    tbl_sat = 0;
    for (int k = 0; k < 8; k++) tbl_sat += tv[k].clips;

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) step();
    load_ramp();

    // Run A: ramp, en held through the whole run.
    step();
    en = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 131) begin
      step();
      if (cyc == t0 + 50) chk("A_busy_mid", busy, 1'b1);
    end
    chk("A_finished_131", {busy, finished}, 2'b11);
    chk("A_sat_final", sat_count, 10'd384);
    en = 1'b0;
    load_table();

    // Run B: table vectors, started in the cycle right after finished.
    step();
    chk("B_idle_132", {busy, finished}, 2'b00);
    en = 1'b1;
    t1 = cyc;
    step();
    en = 1'b0;
    step();
    chk("B_sat_cleared", sat_count, 10'd0);
    while (cyc < t1 + 140) step();
    chk("B_sat_final", sat_count, 10'(tbl_sat));
    check_run("A", t0, t0 + 132, 1'b1);
    check_run("B", t1, t1 + 140, 1'b0);

    // Run C: reset asserted in cycle 60.
    load_ramp();
    step();
    en = 1'b1;
    tc = cyc;
    step();
    en = 1'b0;
    while (cyc < tc + 60) step();
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    step();
    rst = 1'b0;
    repeat (40) step();
    nw = 0;
    foreach (wq[i]) if (wq[i].cyc >= tc && wq[i].cyc < tc + 60) nw++;
    chk("C_writes_before_reset", nw, 14);
    nw = 0;
    foreach (wq[i]) if (wq[i].cyc >= tc + 60 && wq[i].cyc < cyc) nw++;
    foreach (fq[i]) if (fq[i] >= tc && fq[i] < cyc) nw++;
    chk("C_no_activity_after_reset", nw, 0);

    // Run D: full run after the aborted one.
    step();
    en = 1'b1;
    td = cyc;
    step();
    en = 1'b0;
    while (cyc < td + 135) step();
    chk("D_sat_final", sat_count, 10'd384);
    check_run("D", td, td + 135, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
